// File: rtl/vga_pattern_renderer.sv
// vga_pattern_renderer
// ---------------------------------------------------------------------------
// Pixel-colour stage placed after a VGA timing generator. It draws one of
// four test patterns and re-times the syncs so that they stay aligned with
// the colour. Input to output latency is two clocks.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous reset, active low
//   h_sync_in    horizontal sync from the timing generator
//   v_sync_in    vertical sync from the timing generator
//   active_zone  high while (x_pos, y_pos) is a visible pixel
//   x_pos/y_pos  current column / row (11 bit)
//   mode         pattern select: 0 red, 1 bars, 2 checker, 3 bouncing square
//   h_sync       h_sync_in delayed by two clocks
//   v_sync       v_sync_in delayed by two clocks
//   red/green/blue  registered 4-bit colour channels
//   frame_tick   one-cycle pulse after the last visible pixel of a frame
// ---------------------------------------------------------------------------
module vga_pattern_renderer #(
    parameter int   H_ACTIVE   = 640,
    parameter int   V_ACTIVE   = 480,
    parameter int   BOX_SIZE   = 32,
    parameter int   STEP       = 2,
    parameter int   CHECK_LOG2 = 5,
    parameter logic SYNC_IDLE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        active_zone,
    input  logic [10:0] x_pos,
    input  logic [10:0] y_pos,
    input  logic [1:0]  mode,
    output logic        h_sync,
    output logic        v_sync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_tick
);

    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] MAX_X  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0] STEP_W = 12'(STEP);
    localparam logic [11:0] BOX_W  = 12'(BOX_SIZE);
    localparam int          BAR_W  = H_ACTIVE / 8;

    // One axis of the bounce: returns {dir_next, pos_next}. The compare is
    // done one bit wider so that pos+STEP can never wrap, and the downward
    // test is "pos <= STEP" so pos-STEP is only formed when it stays >= 0.
    function automatic logic [11:0] axis_step(input logic [10:0] pos,
                                              input logic        dir,
                                              input logic [10:0] max_pos);
        logic [11:0] result;
        if (dir) begin
            if (({1'b0, pos} + STEP_W) >= {1'b0, max_pos}) begin
                result = {1'b0, max_pos};
            end else begin
                result = {1'b1, pos + STEP_W[10:0]};
            end
        end else begin
            if ({1'b0, pos} <= STEP_W) begin
                result = {1'b1, 11'd0};
            end else begin
                result = {1'b0, pos - STEP_W[10:0]};
            end
        end
        return result;
    endfunction

    // Colour-bar palette, packed as {R, G, B}.
    function automatic logic [11:0] bar_colour(input logic [2:0] bar);
        logic [11:0] rgb;
        case (bar)
            3'd0:    rgb = 12'hFFF;
            3'd1:    rgb = 12'hFF0;
            3'd2:    rgb = 12'h0FF;
            3'd3:    rgb = 12'h0F0;
            3'd4:    rgb = 12'hF0F;
            3'd5:    rgb = 12'hF00;
            3'd6:    rgb = 12'h00F;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

    // Frame-level state
    logic        frame_end_s;
    logic [11:0] x_step_s;
    logic [11:0] y_step_s;
    logic [1:0]  mode_q_r;
    logic [10:0] box_x_r;
    logic [10:0] box_y_r;
    logic        dir_x_r;
    logic        dir_y_r;
    logic        frame_tick_r;

    // Stage 1
    logic [10:0] s1_x_r;
    logic [10:0] s1_y_r;
    logic        s1_active_r;
    logic        s1_hs_r;
    logic        s1_vs_r;
    logic [1:0]  s1_mode_r;
    logic [10:0] s1_box_x_r;
    logic [10:0] s1_box_y_r;

    // Stage 2 / outputs
    logic [2:0]  bar_s;
    logic        in_box_s;
    logic        checker_s;
    logic [11:0] colour_s;
    logic [3:0]  red_r;
    logic [3:0]  green_r;
    logic [3:0]  blue_r;
    logic        h_sync_r;
    logic        v_sync_r;

    assign frame_end_s = active_zone && (x_pos == X_LAST) && (y_pos == Y_LAST);
    assign x_step_s    = axis_step(box_x_r, dir_x_r, MAX_X);
    assign y_step_s    = axis_step(box_y_r, dir_y_r, MAX_Y);

    // Frame-end bookkeeping: latch the mode, advance the square, pulse the tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q_r     <= 2'd0;
            box_x_r      <= 11'd0;
            box_y_r      <= 11'd0;
            dir_x_r      <= 1'b1;
            dir_y_r      <= 1'b1;
            frame_tick_r <= 1'b0;
        end else if (frame_end_s) begin
            mode_q_r     <= mode;
            box_x_r      <= x_step_s[10:0];
            dir_x_r      <= x_step_s[11];
            box_y_r      <= y_step_s[10:0];
            dir_y_r      <= y_step_s[11];
            frame_tick_r <= 1'b1;
        end else begin
            frame_tick_r <= 1'b0;
        end
    end

    // Stage 1: capture the pixel together with the frame state it belongs to.
    // Copying mode/box here keeps the last pixel of a frame on the old
    // settings even though mode_q/box update on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_x_r      <= 11'd0;
            s1_y_r      <= 11'd0;
            s1_active_r <= 1'b0;
            s1_hs_r     <= SYNC_IDLE;
            s1_vs_r     <= SYNC_IDLE;
            s1_mode_r   <= 2'd0;
            s1_box_x_r  <= 11'd0;
            s1_box_y_r  <= 11'd0;
        end else begin
            s1_x_r      <= x_pos;
            s1_y_r      <= y_pos;
            s1_active_r <= active_zone;
            s1_hs_r     <= h_sync_in;
            s1_vs_r     <= v_sync_in;
            s1_mode_r   <= mode_q_r;
            s1_box_x_r  <= box_x_r;
            s1_box_y_r  <= box_y_r;
        end
    end

    // Bar index by comparator chain: count thresholds k*BAR_W that x has reached.
    always_comb begin
        bar_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (s1_x_r >= 11'(k * BAR_W)) begin
                bar_s = bar_s + 3'd1;
            end else begin
                bar_s = bar_s;
            end
        end
    end

    // Square hit test and checker parity, widened so box+size cannot wrap.
    always_comb begin
        in_box_s  = ({1'b0, s1_x_r} >= {1'b0, s1_box_x_r}) &&
                    ({1'b0, s1_x_r} <  ({1'b0, s1_box_x_r} + BOX_W)) &&
                    ({1'b0, s1_y_r} >= {1'b0, s1_box_y_r}) &&
                    ({1'b0, s1_y_r} <  ({1'b0, s1_box_y_r} + BOX_W));
        checker_s = s1_x_r[CHECK_LOG2] ^ s1_y_r[CHECK_LOG2];
    end

    // Pattern select with blanking outside the visible area.
    always_comb begin
        colour_s = 12'h000;
        if (!s1_active_r) begin
            colour_s = 12'h000;
        end else begin
            case (s1_mode_r)
                2'd0:    colour_s = 12'hF00;
                2'd1:    colour_s = bar_colour(bar_s);
                2'd2:    colour_s = checker_s ? 12'hFFF : 12'h000;
                2'd3:    colour_s = in_box_s  ? 12'hFFF : 12'h004;
                default: colour_s = 12'h000;
            endcase
        end
    end

    // Stage 2: register colour with the syncs so both leave together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_r    <= 4'd0;
            green_r  <= 4'd0;
            blue_r   <= 4'd0;
            h_sync_r <= SYNC_IDLE;
            v_sync_r <= SYNC_IDLE;
        end else begin
            red_r    <= colour_s[11:8];
            green_r  <= colour_s[7:4];
            blue_r   <= colour_s[3:0];
            h_sync_r <= s1_hs_r;
            v_sync_r <= s1_vs_r;
        end
    end

    assign red        = red_r;
    assign green      = green_r;
    assign blue       = blue_r;
    assign h_sync     = h_sync_r;
    assign v_sync     = v_sync_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: doc/vga_pattern_renderer.md
# vga_pattern_renderer

Pixel-colour stage that sits directly downstream of the VGA sync/timing generator and drives the board's 4-bit-per-channel RGB pins. It consumes the generator's `h_sync`, `v_sync`, `active_zone`, `x_pos` and `y_pos`, and produces registered RGB plus sync outputs delayed to match. It offers four selectable test patterns: solid red, eight colour bars, a checkerboard and a bouncing square. The square is animated once per frame.

## Interface

Parameters:
- `H_ACTIVE`, 640, visible pixels per line.
- `V_ACTIVE`, 480, visible lines per frame.
- `BOX_SIZE`, 32, side of the bouncing square in pixels.
- `STEP`, 2, square displacement per frame on each axis, in pixels.
- `CHECK_LOG2`, 5, checker cell size is 2^CHECK_LOG2 pixels.
- `SYNC_IDLE`, 1'b1, inactive level of `h_sync`/`v_sync`; also their reset value.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous, active-low.
- `h_sync_in` in 1: horizontal sync from the timing generator.
- `v_sync_in` in 1: vertical sync from the timing generator.
- `active_zone` in 1: high when (`x_pos`, `y_pos`) is a visible pixel.
- `x_pos` in 11: current column.
- `y_pos` in 11: current row.
- `mode` in 2: pattern select, as follows:
  - 0: solid red.
  - 1: colour bars.
  - 2: checkerboard.
  - 3: bouncing square.
- `h_sync` out 1: `h_sync_in` delayed 2 cycles.
- `v_sync` out 1: `v_sync_in` delayed 2 cycles.
- `red` out 4: pixel colour channel.
- `green` out 4: pixel colour channel.
- `blue` out 4: pixel colour channel.
- `frame_tick` out 1: one-cycle pulse after the last visible pixel of each frame.

## Operation

Pipeline:
- Stage 1 registers `x_pos`, `y_pos`, `active_zone` and both syncs.
- Stage 2 computes the colour and registers it alongside the syncs.

Blanking: when the stage-1 `active_zone` is low, RGB = 0/0/0, regardless of mode.

Mode latch:
- `mode` is sampled only on the frame-end event, into `mode_q`.
- Mid-frame changes of `mode` have no effect until the next frame.

Frame-end event: `active_zone`=1 && `x_pos`==`H_ACTIVE`-1 && `y_pos`==`V_ACTIVE`-1 at the input.

On the clock edge after the frame-end event:
- `frame_tick` pulses.
- `mode_q` loads.
- The square position updates.

Patterns (applied to the stage-1 coordinates):
- **Mode 0:** F/0/0.
- **Mode 1:**
  - Bar index b = number of k in 1..7 with x ≥ k·(`H_ACTIVE`/8). Use a comparator chain; no divider.
  - Colours by b, as R/G/B:
    - b=0: F/F/F (white).
    - b=1: F/F/0 (yellow).
    - b=2: 0/F/F (cyan).
    - b=3: 0/F/0 (green).
    - b=4: F/0/F (magenta).
    - b=5: F/0/0 (red).
    - b=6: 0/0/F (blue).
    - b=7: 0/0/0 (black).
- **Mode 2:** `x[CHECK_LOG2]` ^ `y[CHECK_LOG2]`: 1 gives F/F/F, 0 gives 0/0/0.
- **Mode 3:**
  - Inside the square (`box_x` ≤ x < `box_x`+`BOX_SIZE` and `box_y` ≤ y < `box_y`+`BOX_SIZE`): F/F/F.
  - Elsewhere: 0/0/4.

Square motion: position `box_x`/`box_y` (11 bit), direction flags `dir_x`/`dir_y` (1 = increasing). Per axis, with MAX = `H_ACTIVE`-`BOX_SIZE` (x) or `V_ACTIVE`-`BOX_SIZE` (y):
- dir=1, pos+`STEP` ≥ MAX: pos ← MAX, dir ← 0.
- dir=1, otherwise: pos ← pos+`STEP`.
- dir=0, pos ≤ `STEP`: pos ← 0, dir ← 1.
- dir=0, otherwise: pos ← pos−`STEP`.

Arithmetic is unsigned 11-bit. Comparisons must never wrap below 0.

Motion runs every frame in every mode, so that entering mode 3 shows a continuing trajectory.

## Timing

Reset values (`rst` low, asynchronous):
- RGB = 0.
- `h_sync` and `v_sync` = `SYNC_IDLE`.
- `frame_tick` = 0.
- `mode_q` = 0.
- `box_x` = `box_y` = 0.
- `dir_x` = `dir_y` = 1.
- All pipeline registers cleared, with syncs cleared to `SYNC_IDLE`.

Latency:
- Input pixel at cycle N appears on RGB at cycle N+2.
- Syncs sampled at N appear at N+2, so colour/sync alignment is preserved exactly.

Timing of the frame-end event at cycle N:
- `frame_tick`=1 during N+1 only.
- New `mode_q`/position take effect for pixels presented from N+1 onward, i.e. the next frame's first visible pixel.

Reset mid-frame:
- Outputs blank immediately.
- After release, output is valid 2 cycles after the first input sample.
- No `frame_tick` until a full frame-end event is seen.

No input handshake: the block accepts one pixel every clock.

## Test plan

- Reset then mode 0, one 640×480 frame: every visible output pixel is F/0/0; blanking pixels are 0/0/0; `h_sync`/`v_sync` match the inputs delayed exactly 2 cycles.
- Mode 1: x=0 gives F/F/F, x=79 gives F/F/F, x=80 gives F/F/0, x=560 gives 0/0/0, x=639 gives 0/0/0.
- Mode 2: (0,0) gives F/F/F... wait, 0^0=0, so (0,0) gives 0/0/0; (32,0) gives F/F/F; (32,32) gives 0/0/0.
- Mode 3 after reset:
  - Frame 0 draws the square at (0..31, 0..31).
  - After 1 frame, `box_x`=`box_y`=2; pixel (33,33) is F/F/F and (1,1) is 0/0/4.
  - After 304 frames, `box_x` saturates at 608 with `dir_x`→0; the next frame gives 606.
  - After 224 frames, `box_y` saturates at 448 and then reverses.
- `mode` changed 1→3 in mid-frame: the remainder of that frame stays colour bars; the next frame shows the square; `frame_tick` is exactly one pulse per frame.
- Assert `rst` low mid-line: outputs go to 0 and syncs to 1 without waiting for a clock; after release the square restarts at (0,0).
